// File: rtl/bus_grant_encoder_pkg.sv
// bus_enc_pkg: shared constants for the bus grant encoder.
//   ENC_FIXED / ENC_RR : selection mode values for the RR_MODE parameter
//   ERR_CNT_W          : width of the malformed-transfer counter
//   code_w(n)          : source index width for an n-bit request vector
package bus_enc_pkg;

    localparam int ENC_FIXED = 0;
    localparam int ENC_RR    = 1;
    localparam int ERR_CNT_W = 8;

    // Clamp so a degenerate width never yields a zero-width code.
    function automatic int code_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bus_grant_encoder_if.sv
// bus_grant_encoder_if: request/result handshake bundle for bus_grant_encoder.
//   in_valid/in_ready/req                  : request side (valid/ready)
//   out_valid/out_ready                    : result side (valid/ready)
//   out_code/out_none/out_multi            : registered result
//   err_cnt                                : malformed-transfer count
// Modports: slave = encoder side, master = producer/consumer side.
interface bus_grant_encoder_if #(
    parameter int N = 32
) ();
    import bus_enc_pkg::*;

    localparam int W = code_w(N);

    logic                 in_valid;
    logic                 in_ready;
    logic [N-1:0]         req;
    logic                 out_valid;
    logic                 out_ready;
    logic [W-1:0]         out_code;
    logic                 out_none;
    logic                 out_multi;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport slave (
        input  in_valid, req, out_ready,
        output in_ready, out_valid, out_code, out_none, out_multi, err_cnt
    );

    modport master (
        output in_valid, req, out_ready,
        input  in_ready, out_valid, out_code, out_none, out_multi, err_cnt
    );

endinterface

// File: rtl/bus_grant_encoder_rr_pick.sv
// rr_pick: combinational rotate-and-search grant picker.
//   req   : request vector, bit i = source i wants the bus
//   ptr   : search start index (tie to 0 for lowest-bit-first priority)
//   idx   : first set bit at index >= ptr, wrapping past N-1; 0 when req == 0
//   none  : req is all zeros
//   multi : req has two or more bits set
module rr_pick
    import bus_enc_pkg::*;
#(
    parameter  int N = 32,
    localparam int W = code_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         none,
    output logic         multi
);

    localparam logic [W:0]   N_EXT = (W+1)'(N);
    localparam logic [N-1:0] ONE   = N'(1);

    logic [N-1:0] rot;
    logic [W-1:0] off;
    logic [W:0]   sum;

    // Rotate right by ptr so the search always starts at bit 0.
    assign rot = N'({req, req} >> ptr);

    // Descending scan; the last write is the lowest set bit.
    always_comb begin
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) off = W'(i);
        end
    end

    // Un-rotate with an explicit modulo-N wrap, so non-power-of-two N
    // never produces an out-of-range index.
    assign sum   = {1'b0, ptr} + {1'b0, off};
    assign none  = ~|req;
    // Clearing the lowest set bit leaves something iff two or more were set.
    assign multi = |(req & (req - ONE));
    assign idx   = none ? '0 :
                   (sum >= N_EXT) ? W'(sum - N_EXT) : sum[W-1:0];

endmodule

// File: rtl/bus_grant_encoder.sv
// bus_grant_encoder: registered one-of-N request encoder with valid/ready
// handshake; fixed LSB-first priority or round-robin selection.
//   clock : rising-edge clock
//   clear : asynchronous active-low reset
//   bus   : bus_grant_encoder_if.slave (request in, registered result out)
// Parameters: N (2..64) request width, RR_MODE (ENC_FIXED / ENC_RR).
// Build option: define BUS_ENC_ERR_CNT_EN to build the saturating count of
// zero or multi-hot transfers on err_cnt; otherwise err_cnt is tied to 0.
module bus_grant_encoder
    import bus_enc_pkg::*;
#(
    parameter  int N       = 32,
    parameter  int RR_MODE = ENC_FIXED,
    localparam int W       = code_w(N)
) (
    input  logic                clock,
    input  logic                clear,
    bus_grant_encoder_if.slave  bus
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic         out_valid_q;
    logic [W-1:0] code_q;
    logic         none_q;
    logic         multi_q;
    logic [W-1:0] ptr;
    logic [W-1:0] pick_ptr;
    logic [W-1:0] idx;
    logic         none;
    logic         multi;
    logic         in_ready;
    logic         xfer_in;

    // A new request may land in the same cycle the held result drains.
    assign in_ready = !out_valid_q || bus.out_ready;
    assign xfer_in  = bus.in_valid && in_ready;

    assign pick_ptr = (RR_MODE == ENC_RR) ? ptr : '0;

    rr_pick #(.N(N)) u_pick (
        .req   (bus.req),
        .ptr   (pick_ptr),
        .idx   (idx),
        .none  (none),
        .multi (multi)
    );

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            out_valid_q <= 1'b0;
            code_q      <= '0;
            none_q      <= 1'b0;
            multi_q     <= 1'b0;
            ptr         <= '0;
        end else begin
            if (xfer_in) begin
                out_valid_q <= 1'b1;
                code_q      <= idx;
                none_q      <= none;
                multi_q     <= multi;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            // Zero requests leave the pointer where it was.
            if (RR_MODE == ENC_RR && xfer_in && !none) begin
                ptr <= (idx == LAST) ? '0 : idx + W'(1);
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_code  = code_q;
    assign bus.out_none  = none_q;
    assign bus.out_multi = multi_q;

`ifdef BUS_ENC_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_q;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            err_q <= '0;
        end else if (xfer_in && (none || multi) && (err_q != '1)) begin
            err_q <= err_q + ERR_CNT_W'(1);
        end
    end

    assign bus.err_cnt = err_q;
`else
    assign bus.err_cnt = '0;
`endif

endmodule

// File: doc/bus_grant_encoder.md
# bus_grant_encoder

Parametrised, registered successor to the combinational one-hot bus encoder. It accepts an N-bit request vector over a valid/ready handshake and returns a W-bit source index one cycle later, plus flags for no requests and for more than one request. The source index selects the bus driver, and the block sits between the register/port enable logic and the bus multiplexer. Two selection modes are available: fixed LSB-first priority and round-robin with a rotating pointer.

## Interface
- `N`, 32: request vector width; valid range 2..64.
- `W`, $clog2(N): code width; derived, not overridden (5 for N=32).
- `RR_MODE`, 0: 0 = fixed priority, lowest set bit wins; 1 = round-robin.
- `clock` in 1: single clock; all state updates on the rising edge.
- `clear` in 1: asynchronous active-low reset; asserted at 0.
- `in_valid` in 1: `req` is presented for encoding.
- `in_ready` out 1: the block can accept `req` this cycle.
- `req` in N: request/enable vector; bit i means source i wants the bus.
- `out_valid` out 1: the output register holds a result.
- `out_ready` in 1: the consumer takes the result this cycle.
- `out_code` out W: selected source index.
- `out_none` out 1: the captured `req` was all zeros.
- `out_multi` out 1: the captured `req` had two or more bits set.
- `err_cnt` out 8: saturating count of malformed transfers. See Configuration.

## Operation
- Transfer in: `in_valid && in_ready`. Transfer out: `out_valid && out_ready`.
- `in_ready = !out_valid || out_ready`. This is combinational, so a new input is accepted in the same cycle the old result drains.
- Selection:
  - Fixed mode: index of the lowest set bit of `req`.
  - Round-robin mode: first set bit at index ≥ `ptr`, wrapping to index 0 after N-1.
- For a one-hot `req`, both modes return that bit's index. This is identical to the legacy encoder.
- `req` == 0: `out_code` = 0, `out_none` = 1, `out_multi` = 0.
- `out_multi` is set when `popcount(req)` ≥ 2. The code is still the selected index.
- Round-robin pointer `ptr` (W bits):
  - On an input transfer with nonzero `req` and selected index i: `ptr <= i+1`, or 0 when i == N-1.
  - Wrap is explicit and correct for N that is not a power of two.
  - On a zero `req`, `ptr` holds.
  - In fixed mode, `ptr` stays 0.
- The output register (`out_code`, `out_none`, `out_multi`) loads only on an input transfer.
- `out_valid` update per cycle:
  - Set on an input transfer.
  - Cleared on an output transfer without an input transfer.
  - Unchanged otherwise.
- `req` is ignored while `in_valid` = 0.
- Reset value of every output and state element is 0: `out_valid`, `out_code`, `out_none`, `out_multi`, `err_cnt`, `ptr`. `in_ready` = 1 during and after reset.
- Reset mid-operation discards any held result. There is no partial update.

## Timing
- Latency: 1 cycle from input transfer to `out_valid`.
- Throughput: 1 result per cycle while `out_ready` = 1.
- Backpressure: with `out_valid` = 1 and `out_ready` = 0, the result and `in_ready` = 0 hold for any number of cycles. An upstream `req` change is not captured.
- The critical path is the N-bit rotate-and-search. At N=32 it must fit a single cycle.

## Configuration
- `BUS_ENC_ERR_CNT_EN` defined:
  - `err_cnt` increments on each input transfer whose `req` is zero or multi-hot.
  - It saturates at 255 and clears only on reset.
  - A malformed transfer in the same cycle as saturation leaves it at 255.
- Not defined: `err_cnt` is tied to 0, no counter flops are built, and the port list is unchanged.

## Structure
- Package `bus_enc_pkg`:
  - Mode constants `ENC_FIXED` = 0 and `ENC_RR` = 1.
  - `ERR_CNT_W` = 8.
  - Function computing W from N.
- Sub-module `rr_pick`: combinational; inputs `req[N]` and `ptr[W]`; outputs `idx[W]`, `none`, `multi`. It is instantiated once, with `ptr` forced to 0 in fixed mode.
- Top level holds the handshake, output register, pointer and error counter.

## Test plan
- Fixed mode, N=32: apply each of the 32 one-hot values, `out_ready` = 1 → `out_code` = 0..31, one cycle later, with `out_none` = `out_multi` = 0.
- Round-robin mode, N=32, `req` = 0x0000_0011 held for 4 transfers → codes 0, 4, 0, 4 and `ptr` = 1, 5, 1, 5.
- Round-robin mode, N=6, `req` = 6'b100001 → codes 0, 5, 0; `ptr` wraps from 6 to 0 with no out-of-range value.
- Backpressure: `out_ready` = 0 for 3 cycles after code 7 → `out_code` holds 7 and `in_ready` = 0. The `req` change in those cycles is ignored, and the next accepted `req` appears after `out_ready` rises.
- `req` = 0 then `req` = 0x3 (fixed mode) → code 0 with `out_none` = 1, then code 0 with `out_multi` = 1. With `BUS_ENC_ERR_CNT_EN` defined, `err_cnt` = 2; after 300 malformed transfers, `err_cnt` = 255.
- Assert `clear` = 0 while `out_valid` = 1 and `ptr` = 9 → all outputs and `ptr` = 0 immediately, and `in_ready` = 1 after release.
